// File: rtl/ram_if_pkg.sv
// Shared RAM interface definitions: response entry layout {err, data}, its width,
// and the signed-index to physical-address translation used by the front end and the RAM.
package ram_if_pkg;

    localparam int unsigned RSP_DATA_W = 8;
    localparam int unsigned RSP_W      = RSP_DATA_W + 1;

    typedef struct packed {
        logic                  err;
        logic [RSP_DATA_W-1:0] data;
    } rsp_entry_t;

    function automatic int unsigned rsp_width(input int unsigned data_width);
        return data_width + 1;
    endfunction

    // Negative indices count back from len; the result wraps to aw bits.
    function automatic int unsigned to_phys(input int index, input int unsigned len,
                                            input int unsigned aw);
        int unsigned mask;
        int unsigned raw;
        mask = (32'd1 << aw) - 32'd1;
        raw  = (index < 0) ? len + unsigned'(index) : unsigned'(index);
        return raw & mask;
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Two-entry response FIFO with asynchronous reset; output comes straight from the
// storage registers, so a pushed entry is visible on dout the cycle after the push.
module ram_rsp_fifo
    import ram_if_pkg::*;
#(
    parameter int unsigned WIDTH = RSP_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count_q;

    // Upstream flow control guarantees no push when full and no pop when empty.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/ram_access_frontend.sv
// Valid/ready front end for a single-port RAM with 1-cycle read latency; translates signed
// indices, returns ordered responses. Macro RAM_BOUNDS_CHECK_EN enables range errors.
module ram_access_frontend
    import ram_if_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RAM_LENGTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_INDEX,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  RSP_ERR,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [DATA_WIDTH-1:0] RAM_D,
    output logic                  RAM_WE,
    input  logic [DATA_WIDTH-1:0] RAM_Q
);

    localparam int unsigned ENTRY_W = rsp_width(DATA_WIDTH);

    int                    index_s;
    logic                  err;
    logic                  acc;
    logic                  pop;
    logic                  s1_valid;
    logic                  s1_we;
    logic                  s1_err;
    logic [1:0]            fifo_count;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] push_data;
    logic [ENTRY_W-1:0]    push_entry;
    logic [ENTRY_W-1:0]    head_entry;

    always_comb begin
        index_s  = int'($signed(REQ_INDEX));
        RAM_ADDR = ADDR_WIDTH'(to_phys(index_s, RAM_LENGTH, ADDR_WIDTH));
`ifdef RAM_BOUNDS_CHECK_EN
        err      = (index_s >= int'(RAM_LENGTH)) || (index_s < -int'(RAM_LENGTH));
`else
        err      = 1'b0;
`endif
    end

    // Accept while fewer than two responses are owed, or one leaves this cycle.
    always_comb begin
        occ       = fifo_count + {1'b0, s1_valid};
        RSP_VALID = (fifo_count != 2'd0);
        pop       = RSP_VALID && RSP_READY;
        REQ_READY = !RST && ((occ < 2'd2) || pop);
        acc       = REQ_VALID && REQ_READY;
        RAM_WE    = acc && REQ_WE && !err;
        RAM_D     = REQ_WDATA;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_we    <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= acc;
            if (acc) begin
                s1_we  <= REQ_WE;
                s1_err <= err;
            end
        end
    end

    // RAM_Q belongs to the request held in s1; captured before any write at this edge lands.
    always_comb begin
        push_data  = (!s1_we && !s1_err) ? RAM_Q : '0;
        push_entry = {s1_err, push_data};
    end

    ram_rsp_fifo #(
        .WIDTH (ENTRY_W)
    ) u_rsp_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (s1_valid),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .count (fifo_count)
    );

    assign RSP_ERR  = head_entry[ENTRY_W-1];
    assign RSP_DATA = head_entry[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_ram_access_frontend.sv
// Scoreboard bench for ram_access_frontend: a sequential memory model predicts every
// response, a monitor pops and compares whenever a response is consumed.
module tb_ram_access_frontend;

    localparam int DW    = 8;
    // Five index bits so that out-of-range indices such as 12 and -11 are expressible.
    localparam int AW    = 5;
    localparam int LEN   = 10;
    localparam int DEPTH = 1 << AW;
`ifdef RAM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          CLK       = 1'b0;
    logic          RST       = 1'b0;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WE    = 1'b0;
    logic [AW-1:0] REQ_INDEX = '0;
    logic [DW-1:0] REQ_WDATA = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b0;
    logic [DW-1:0] RSP_DATA;
    logic          RSP_ERR;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_D;
    logic          RAM_WE;
    logic [DW-1:0] RAM_Q;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        bit            chk_data;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    bit            written   [DEPTH];
    logic [DW-1:0] ram_mem   [DEPTH];
    logic [DW-1:0] ram_q;

    int n_cmp    = 0;
    int n_bad    = 0;
    int cycle    = 0;
    int n_acc    = 0;
    int rsp_mode = 0;  // 0: always ready, 1: random, 2: held low

    ram_access_frontend #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RAM_LENGTH (LEN)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WE    (REQ_WE),
        .REQ_INDEX (REQ_INDEX),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_DATA  (RSP_DATA),
        .RSP_ERR   (RSP_ERR),
        .RAM_ADDR  (RAM_ADDR),
        .RAM_D     (RAM_D),
        .RAM_WE    (RAM_WE),
        .RAM_Q     (RAM_Q)
    );

    always #5 CLK = ~CLK;

    // Single-port RAM: registered address, read-first.
    always @(posedge CLK) begin
        cycle <= cycle + 1;
        if (RAM_WE) ram_mem[RAM_ADDR] <= RAM_D;
        ram_q <= ram_mem[RAM_ADDR];
    end
    assign RAM_Q = ram_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic monitor_step();
        bit   exp_rv;
        bit   exp_rr;
        bit   err;
        bit   we;
        int   idx;
        int   phys;
        exp_t e;
        exp_t h;
        check("occupancy_le_2", (exp_q.size() <= 2), 1);
        exp_rv = 1'b0;
        if (exp_q.size() > 0) exp_rv = (exp_q[0].cyc + 2 <= cycle);
        check("rsp_valid", RSP_VALID, exp_rv);
        exp_rr = (exp_q.size() < 2) || (exp_rv && RSP_READY);
        check("req_ready", REQ_READY, exp_rr);
        if (RSP_VALID && RSP_READY) begin
            if (exp_q.size() == 0) begin
                check("spurious_rsp", RSP_VALID, 0);
            end else begin
                h = exp_q.pop_front();
                check("rsp_err", RSP_ERR, h.err);
                if (h.chk_data) check("rsp_data", RSP_DATA, h.data);
            end
        end
        if (REQ_VALID && REQ_READY) begin
            idx  = int'($signed(REQ_INDEX));
            we   = REQ_WE;
            phys = (idx < 0) ? LEN + idx : idx;
            phys = ((phys % DEPTH) + DEPTH) % DEPTH;
            err  = BOUNDS && ((idx >= LEN) || (idx < -LEN));
            check("ram_addr", RAM_ADDR, phys);
            check("ram_we", RAM_WE, we && !err);
            e.err      = err;
            e.cyc      = cycle;
            e.chk_data = 1'b1;
            e.data     = '0;
            if (!we && !err) begin
                e.data     = model_mem[phys];
                e.chk_data = written[phys];
            end
            if (we && !err) begin
                model_mem[phys] = REQ_WDATA;
                written[phys]   = 1'b1;
            end
            exp_q.push_back(e);
            n_acc++;
        end else begin
            check("ram_we_idle", RAM_WE, 0);
        end
    endtask

    initial forever begin
        @(negedge CLK);
        #3;
        if (!RST) monitor_step();
    end

    initial forever begin
        @(negedge CLK);
        case (rsp_mode)
            0:       RSP_READY = 1'b1;
            1:       RSP_READY = 1'($urandom_range(0, 1));
            default: RSP_READY = 1'b0;
        endcase
    end

    task automatic send(input bit we, input logic [AW-1:0] idx, input logic [DW-1:0] wd);
        int budget = 100;
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_INDEX = idx;
        REQ_WDATA = wd;
        #3;
        while (!REQ_READY && budget > 0) begin
            @(negedge CLK);
            #3;
            budget--;
        end
        if (budget == 0) check("req_accept_timeout", REQ_READY, 1);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic drain();
        int budget = 200;
        rsp_mode = 0;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        check("drain_outstanding", exp_q.size(), 0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int n0;
        #1 RST = 1'b1;
        #1;
        check("reset_rsp_valid", RSP_VALID, 0);
        check("reset_rsp_data", RSP_DATA, 0);
        check("reset_rsp_err", RSP_ERR, 0);
        check("reset_req_ready", REQ_READY, 0);
        check("reset_ram_we", RAM_WE, 0);
        @(negedge CLK);
        #1 RST = 1'b0;

        // Write then read back, and negative index aliasing.
        send(1'b1, AW'(3), 8'hA5);
        send(1'b0, AW'(3), 8'h00);
        send(1'b1, AW'(9), 8'h3C);
        send(1'b0, AW'(-1), 8'h00);
        drain();

        // Back-to-back stream with the consumer always ready.
        for (int i = 0; i < LEN; i++) send(1'b0, AW'(i), 8'h00);
        drain();

        // Same stream against a stalled consumer.
        rsp_mode = 2;
        repeat (2) @(negedge CLK);
        n0 = n_acc;
        fork
            begin
                for (int i = 0; i < LEN; i++) send(1'b0, AW'(i), 8'h00);
            end
            begin
                repeat (6) @(negedge CLK);
                #3;
                check("bp_accepts", n_acc - n0, 2);
                check("bp_req_ready_low", REQ_READY, 0);
                rsp_mode = 0;
            end
        join
        drain();
        check("bp_total_accepts", n_acc - n0, LEN);

        // Out-of-range write and read.
        send(1'b1, AW'(12), 8'hFF);
        send(1'b0, AW'(-11), 8'h00);
        drain();

        // Randomised traffic under random backpressure.
        rsp_mode = 1;
        for (int i = 0; i < 150; i++) begin
            send(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge CLK);
        end
        drain();

        // Reset with two responses outstanding.
        send(1'b1, AW'(3), 8'hA5);
        drain();
        rsp_mode = 2;
        repeat (2) @(negedge CLK);
        send(1'b0, AW'(3), 8'h00);
        send(1'b0, AW'(9), 8'h00);
        @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        check("midreset_rsp_valid", RSP_VALID, 0);
        check("midreset_req_ready", REQ_READY, 0);
        check("midreset_ram_we", RAM_WE, 0);
        check("midreset_rsp_data", RSP_DATA, 0);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        #1 RST = 1'b0;
        rsp_mode = 0;
        send(1'b0, AW'(3), 8'h00);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
